// File: rtl/pe_bus_responder.sv
// Operand/memory responder for a processing element: a 32x32 register file with
// write bypass, plus a word-addressed data memory with configurable wait states.
module pe_bus_responder #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_en,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        rdWrite,
    input  logic [31:0] result_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    output logic [31:0] a_data,
    output logic [31:0] b_data,
    output logic        data_Ready,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        busy
);

    localparam int unsigned DW       = 32;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam int unsigned CW       = 4;
    localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);
    localparam logic [CW-1:0] LAT_LAST = CW'((MEM_LAT == 0) ? 0 : (MEM_LAT - 1));

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESP     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [AW-1:0]   idx_q, idx_next;
    logic [DW-1:0]   wdata_q, wdata_next;
    logic            is_wr_q, is_wr_next;
    logic            fault_q, fault_next;

    logic [DW-1:0]   a_next, b_next;
    logic            rdy_next, ack_next, err_next;
    logic            fire;
    logic            mem_we;
    logic            req_fault;
    logic [DW-1:0]   op_a, op_b;

    logic [DW-1:0]   regs [NREGS];
    logic [DW-1:0]   mem  [MEM_WORDS];

    // Misaligned or out-of-range byte addresses fault
    assign req_fault = (mem_address[1:0] != 2'b00) || ({1'b0, mem_address} >= MEM_BYTES);

    // Operand fetch with same-cycle write bypass; x0 is hardwired to zero
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (rs1 != 5'd0) begin
            op_a = (rdWrite && (rd == rs1)) ? result_in : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            op_b = (rdWrite && (rd == rs2)) ? result_in : regs[rs2];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx_q;
        wdata_next = wdata_q;
        is_wr_next = is_wr_q;
        fault_next = fault_q;
        a_next     = a_data;
        b_next     = b_data;
        rdy_next   = 1'b0;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        fire       = 1'b0;
        mem_we     = 1'b0;

        case (state)
            IDLE: begin
                if (mem_write || mem_read) begin
                    idx_next   = mem_address[AW+1:2];
                    wdata_next = result_in;
                    is_wr_next = mem_write;
                    fault_next = req_fault;
                    cnt_next   = '0;
                    if (MEM_LAT == 0) begin
                        fire = 1'b1;
                    end else begin
                        state_next = MEM_WAIT;
                    end
                end else if (read_en) begin
                    a_next     = op_a;
                    b_next     = op_b;
                    rdy_next   = 1'b1;
                    state_next = RESP;
                end
            end
            MEM_WAIT: begin
                if (cnt == LAT_LAST) begin
                    fire = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RESP: begin
                state_next = DONE;
            end
            DONE: begin
                if (!read_en && !mem_read && !mem_write) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Completion of a memory access; uses the values being latched so a
        // zero-latency access completes in its acceptance cycle
        if (fire) begin
            ack_next   = 1'b1;
            err_next   = fault_next;
            cnt_next   = '0;
            state_next = RESP;
            if (is_wr_next) begin
                mem_we = !fault_next;
            end else begin
                a_next = fault_next ? '0 : mem[idx_next];
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            fault_q    <= 1'b0;
            a_data     <= '0;
            b_data     <= '0;
            data_Ready <= 1'b0;
            mem_ack    <= 1'b0;
            mem_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx_q      <= idx_next;
            wdata_q    <= wdata_next;
            is_wr_q    <= is_wr_next;
            fault_q    <= fault_next;
            a_data     <= a_next;
            b_data     <= b_next;
            data_Ready <= rdy_next;
            mem_ack    <= ack_next;
            mem_err    <= err_next;
            busy       <= (state_next != IDLE);
        end
    end

    // Register file: cleared on reset, x0 never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rdWrite && (rd != 5'd0)) begin
            regs[rd] <= result_in;
        end
    end

    // Data memory keeps its contents across reset; reset aborts a pending store
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[idx_next] <= wdata_next;
        end
    end

endmodule

// File: doc/pe_bus_responder.md
PE_BUS_RESPONDER -- requirements
Module: pe_bus_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning data-memory depth in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter MEM_LAT, default 2, meaning wait cycles inserted before mem_ack (0..15).
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-004 SHALL have: reset  in  1  synchronous active-high reset.
REQ-005 SHALL have: read_en  in  1  register-operand read request, level held until data_ready.
REQ-006 SHALL have: rs1, rs2  in  5 each  register-operand addresses.
REQ-007 SHALL have: rd  in  5  destination register address.
REQ-008 SHALL have: rdWrite  in  1  single-cycle register write strobe.
REQ-009 SHALL have: result_in  in  32  write data for register writes and stores.
REQ-010 SHALL have: mem_read, mem_write  in  1 each  load/store requests, level held until mem_ack.
REQ-011 SHALL have: mem_address  in  32  byte address for load/store.
REQ-012 SHALL have: a_data, b_data  out  32 each  operand data, fed to the PE's AmuxIn/BmuxIn.
REQ-013 SHALL have: data_Ready  out  1  one-cycle pulse, register operands valid.
REQ-014 SHALL have: mem_ack  out  1  one-cycle pulse, load/store complete.
REQ-015 SHALL have: mem_err  out  1  one-cycle pulse coincident with mem_ack on a faulted access.
REQ-016 SHALL have: busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL hold a 32x32 register file; x0 reads as 0, writes to x0 are discarded.
REQ-018 SHALL perform rdWrite in the cycle it is sampled, in any FSM state, independent of other requests.
REQ-019 SHALL implement FSM states IDLE, MEM_WAIT, RESP, DONE.
REQ-020 SHALL, in IDLE, accept one request with priority mem_write > mem_read > read_en; lower-priority requests stay pending.
REQ-021 SHALL, on read_en accepted in cycle T, drive a_data=reg[rs1], b_data=reg[rs2] and data_Ready=1 in T+1, then go to DONE.
REQ-022 SHALL bypass: if rdWrite in cycle T targets rs1 or rs2 (non-zero), the returned operand is result_in of cycle T.
REQ-023 SHALL, on mem_read/mem_write accepted in cycle T, latch address/data, count MEM_LAT cycles in MEM_WAIT, and pulse mem_ack in cycle T+1+MEM_LAT (MEM_LAT=0 skips MEM_WAIT).
REQ-024 SHALL, for loads, drive a_data=mem[mem_address[k+1:2]] (k=log2 MEM_WORDS) in the mem_ack cycle; b_data unchanged.
REQ-025 SHALL, for stores, write result_in latched at acceptance to memory in the mem_ack cycle.
REQ-026 SHALL flag a fault when mem_address[1:0]!=0 or mem_address>=4*MEM_WORDS: mem_ack and mem_err pulse together, stores are suppressed, loads return a_data=0.
REQ-027 SHALL, in DONE, stay until read_en, mem_read and mem_write are all low, then return to IDLE (no double service of a held request).
REQ-028 SHALL hold a_data/b_data stable between responses.
REQ-029 SHALL drive all outputs from registers.

Reset
REQ-030 SHALL, on reset, force IDLE, clear the MEM_LAT counter, set a_data=0, b_data=0, data_Ready=0, mem_ack=0, mem_err=0, busy=0.
REQ-031 SHALL clear all 32 registers to 0 on reset; data memory contents are not cleared.
REQ-032 SHALL abort any in-flight access on reset mid-operation: no memory write, no ack.
REQ-033 SHALL ignore rdWrite in a reset cycle.

Verification
REQ-034 Reg read: rdWrite rd=5 data 0x1234; next cycle read_en rs1=5 rs2=0 -> T+1 a_data=0x1234, b_data=0, data_Ready one pulse.
REQ-035 Bypass: rdWrite rd=3 data 0xAA same cycle as accepted read_en rs1=3 -> a_data=0xAA.
REQ-036 Store/load, MEM_LAT=2: mem_write addr 0x10 data 0xDEADBEEF accepted T -> mem_ack at T+3; then mem_read 0x10 -> a_data=0xDEADBEEF with mem_ack at T'+3.
REQ-037 Fault: mem_write addr 0x11 -> mem_ack+mem_err pulse, subsequent load of 0x10 unchanged; load addr 4*MEM_WORDS -> a_data=0, mem_err=1.
REQ-038 Priority/hold: read_en and mem_read raised together -> load served first, read_en served only after requests drop and reassert; held request gets exactly one response.
REQ-039 Reset mid-store: reset asserted during MEM_WAIT -> no mem_ack, memory word unchanged, all outputs 0, registers 0.
